// File: rtl/bus_xfer_if.sv
// Request handshake and register-bank strobe bundle between a requester/register bank and bus_xfer_ctrl.
// The controller side uses the slave modport; the requester side uses the master modport.
`timescale 1ns/1ps
interface bus_xfer_if #(
    parameter int REG_COUNT = 8,
    parameter int BIT_COUNT = 8
);
    localparam int IDX_W = $clog2(REG_COUNT);

    logic                 req_valid;
    logic                 req_ready;
    logic [IDX_W-1:0]     req_src;
    logic [IDX_W-1:0]     req_dst;
    logic                 req_imm;
    logic [BIT_COUNT-1:0] req_data;
    logic [REG_COUNT-1:0] read_en;
    logic [REG_COUNT-1:0] write_en;
    logic                 xfer_done;
    logic                 xfer_err;
    logic [7:0]           xfer_count;

    modport master (
        output req_valid, req_src, req_dst, req_imm, req_data,
        input  req_ready, read_en, write_en, xfer_done, xfer_err, xfer_count
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_imm, req_data,
        output req_ready, read_en, write_en, xfer_done, xfer_err, xfer_count
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register move sequencer for a shared tri-state bus: IDLE -> DRIVE -> LATCH.
// Define BUS_XFER_IMM_EN to let a request source the bus from req_data instead of a register.
`timescale 1ns/1ps
module bus_xfer_ctrl #(
    parameter int REG_COUNT = 8,
    parameter int BIT_COUNT = 8,
    localparam int IDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_xfer_if.slave            bus,
    output wire  [BIT_COUNT-1:0] bus_out
);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

    localparam logic [IDX_W:0] REG_LIMIT = REG_COUNT[IDX_W:0];

    state_t               state_reg, state_next;
    logic [REG_COUNT-1:0] read_en_reg, read_en_next;
    logic [REG_COUNT-1:0] write_en_reg, write_en_next;
    logic [REG_COUNT-1:0] dst_hot_reg, dst_hot_next;
    logic                 imm_reg, imm_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic [7:0]           count_reg;
    logic                 drive_imm_next;
    logic                 start_xfer;

    logic [REG_COUNT-1:0] src_hot, dst_hot;
    logic                 req_is_imm;
    logic                 src_bad, dst_bad, self_move, accept;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_dec
            assign src_hot[gi] = (bus.req_src == IDX_W'(gi));
            assign dst_hot[gi] = (bus.req_dst == IDX_W'(gi));
        end
    endgenerate

`ifdef BUS_XFER_IMM_EN
    assign req_is_imm = bus.req_imm;
`else
    assign req_is_imm = 1'b0;
`endif

    // Out-of-range indices only exist when REG_COUNT is not a power of two.
    assign src_bad   = !req_is_imm && ({1'b0, bus.req_src} >= REG_LIMIT);
    assign dst_bad   = {1'b0, bus.req_dst} >= REG_LIMIT;
    assign self_move = !req_is_imm && (bus.req_src == bus.req_dst);
    assign accept    = (state_reg == IDLE) && bus.req_valid;

    assign bus.req_ready = (state_reg == IDLE) && !rst;

    // Strobes are computed one cycle ahead so that every output leaves a flop.
    always_comb begin
        state_next     = state_reg;
        read_en_next   = '0;
        write_en_next  = '0;
        dst_hot_next   = dst_hot_reg;
        imm_next       = imm_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        drive_imm_next = 1'b0;
        start_xfer     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (src_bad || dst_bad) begin
                        err_next = 1'b1;
                    end else if (self_move) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = DRIVE;
                        start_xfer     = 1'b1;
                        dst_hot_next   = dst_hot;
                        imm_next       = req_is_imm;
                        drive_imm_next = req_is_imm;
                        read_en_next   = req_is_imm ? '0 : src_hot;
                    end
                end
            end
            DRIVE: begin
                state_next     = LATCH;
                read_en_next   = read_en_reg;
                drive_imm_next = imm_reg;
                write_en_next  = dst_hot_reg;
            end
            LATCH: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            read_en_reg  <= '0;
            write_en_reg <= '0;
            dst_hot_reg  <= '0;
            imm_reg      <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            read_en_reg  <= read_en_next;
            write_en_reg <= write_en_next;
            dst_hot_reg  <= dst_hot_next;
            imm_reg      <= imm_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            count_reg    <= count_reg + 8'(done_next);
        end
    end

    assign bus.read_en    = read_en_reg;
    assign bus.write_en   = write_en_reg;
    assign bus.xfer_done  = done_reg;
    assign bus.xfer_err   = err_reg;
    assign bus.xfer_count = count_reg;

`ifdef BUS_XFER_IMM_EN
    logic                 drive_reg;
    logic [BIT_COUNT-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            drive_reg <= drive_imm_next;
            if (start_xfer) begin
                data_reg <= bus.req_data;
            end
        end
    end

    assign bus_out = drive_reg ? data_reg : {BIT_COUNT{1'bz}};
`else
    logic unused_imm;
    assign unused_imm = ^{bus.req_imm, bus.req_data, drive_imm_next, start_xfer};
    assign bus_out    = {BIT_COUNT{1'bz}};
`endif

endmodule
